// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle MIPS-subset controller.
// Optional TRAP state exists only when MC_ILLEGAL_TRAP_EN is defined.
`timescale 1ns/1ps
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        S_TRAP = 3'd5
`endif
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational decode of latched Op/Fuc into datapath mux
// controls and a legal-instruction flag.
`timescale 1ns/1ps
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] fuc,
    output logic [2:0] aluctr,
    output logic       extop,
    output logic       alusrc,
    output logic       regdst,
    output logic       legal
);

    always_comb begin
        aluctr = ALU_ADD;
        extop  = 1'b0;
        alusrc = 1'b0;
        regdst = 1'b0;
        legal  = 1'b0;
        unique case (1'b1)
            (op == OP_R): begin
                regdst = 1'b1;
                legal  = 1'b1;
                unique case (1'b1)
                    (fuc == FN_ADDU): aluctr = ALU_ADD;
                    (fuc == FN_SUBU): aluctr = ALU_SUB;
                    (fuc == FN_AND):  aluctr = ALU_AND;
                    (fuc == FN_OR):   aluctr = ALU_OR;
                    (fuc == FN_SLT):  aluctr = ALU_SLT;
                    default: begin
                        regdst = 1'b0;
                        legal  = 1'b0;
                    end
                endcase
            end
            (op == OP_ORI): begin
                alusrc = 1'b1;
                aluctr = ALU_OR;
                legal  = 1'b1;
            end
            (op == OP_ADDIU),
            (op == OP_LW),
            (op == OP_SW): begin
                alusrc = 1'b1;
                extop  = 1'b1;
                legal  = 1'b1;
            end
            (op == OP_BEQ): begin
                aluctr = ALU_SUB;
                legal  = 1'b1;
            end
            (op == OP_J): legal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with MEM wait timeout.
// Define MC_ILLEGAL_TRAP_EN to trap on unknown instructions.
`timescale 1ns/1ps
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int ALUCTR_W = 3,
    parameter int MEM_TO   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          Op,
    input  logic [5:0]          Fuc,
    input  logic                mem_rdy,
    output logic                PCWr,
    output logic                IRWr,
    output logic                Branch,
    output logic                Jump,
    output logic                RegDst,
    output logic                ALUsrc,
    output logic [ALUCTR_W-1:0] ALUctr,
    output logic                ExtOp,
    output logic                MemtoReg,
    output logic                RegWr,
    output logic                MemWr,
    output logic                retire,
    output logic                mem_err
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic                illegal
`endif
);

    localparam int CNT_W =
        (MEM_TO > 0) ? $clog2(MEM_TO + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TO);
    localparam bit TO_EN = (MEM_TO != 0);

    state_t           state_q, state_d;
    logic [5:0]       op_q, fuc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       alu3;
    logic             timeout;

    logic [2:0] dec_aluctr;
    logic       dec_extop, dec_alusrc;
    logic       dec_regdst, dec_legal;

    logic is_j, is_beq, is_lw, is_sw;

    mc_alu_dec u_dec (
        .op     (op_q),
        .fuc    (fuc_q),
        .aluctr (dec_aluctr),
        .extop  (dec_extop),
        .alusrc (dec_alusrc),
        .regdst (dec_regdst),
        .legal  (dec_legal)
    );

    assign is_j   = (op_q == OP_J);
    assign is_beq = (op_q == OP_BEQ);
    assign is_lw  = (op_q == OP_LW);
    assign is_sw  = (op_q == OP_SW);

    assign ALUctr = ALUCTR_W'(alu3);

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal = !rst && (state_q == S_TRAP);
`endif

    // Outputs are gated by rst so an aborted instruction writes nothing.
    always_comb begin
        state_d  = state_q;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        RegDst   = 1'b0;
        ALUsrc   = 1'b0;
        alu3     = ALU_ADD;
        ExtOp    = 1'b0;
        MemtoReg = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        retire   = 1'b0;
        timeout  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    IRWr    = 1'b1;
                    state_d = S_ID;
                end
                S_ID: begin
                    if (is_j) begin
                        Jump    = 1'b1;
                        PCWr    = 1'b1;
                        retire  = 1'b1;
                        state_d = S_IF;
`ifdef MC_ILLEGAL_TRAP_EN
                    end else if (!dec_legal) begin
                        state_d = S_TRAP;
`endif
                    end else begin
                        state_d = S_EX;
                    end
                end
                S_EX: begin
                    alu3   = dec_aluctr;
                    ALUsrc = dec_alusrc;
                    ExtOp  = dec_extop;
                    RegDst = dec_regdst;
                    if (is_beq) begin
                        Branch  = 1'b1;
                        PCWr    = 1'b1;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else if (is_lw || is_sw) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    alu3   = dec_aluctr;
                    ALUsrc = dec_alusrc;
                    ExtOp  = dec_extop;
                    if (mem_rdy) begin
                        // store commits in its final MEM cycle
                        MemWr = is_sw;
                        if (is_sw) begin
                            PCWr    = 1'b1;
                            retire  = 1'b1;
                            state_d = S_IF;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (TO_EN && cnt_q == CNT_MAX) begin
                        timeout = 1'b1;
                        PCWr    = 1'b1;
                        state_d = S_IF;
                    end else begin
                        MemWr = is_sw;
                    end
                end
                S_WB: begin
                    PCWr    = 1'b1;
                    retire  = 1'b1;
                    RegWr   = dec_legal;
                    state_d = S_IF;
                    if (is_lw) begin
                        MemtoReg = 1'b1;
                    end else begin
                        alu3   = dec_aluctr;
                        ALUsrc = dec_alusrc;
                        ExtOp  = dec_extop;
                        RegDst = dec_regdst;
                    end
                end
`ifdef MC_ILLEGAL_TRAP_EN
                S_TRAP: state_d = S_TRAP;
`endif
                default: state_d = S_IF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            op_q    <= '0;
            fuc_q   <= '0;
            cnt_q   <= '0;
            mem_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IF) begin
                op_q  <= Op;
                fuc_q <= Fuc;
            end
            if (state_q != S_MEM) begin
                cnt_q <= '0;
            end else if (!mem_rdy && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table plus
// hand sequences for MEM waits, timeout and mid-instruction reset.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Fuc;
    logic       mem_rdy;
    logic       PCWr, IRWr, Branch, Jump, RegDst, ALUsrc;
    logic [2:0] ALUctr;
    logic       ExtOp, MemtoReg, RegWr, MemWr, retire, mem_err;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.ALUCTR_W(3), .MEM_TO(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .Op       (Op),
        .Fuc      (Fuc),
        .mem_rdy  (mem_rdy),
        .PCWr     (PCWr),
        .IRWr     (IRWr),
        .Branch   (Branch),
        .Jump     (Jump),
        .RegDst   (RegDst),
        .ALUsrc   (ALUsrc),
        .ALUctr   (ALUctr),
        .ExtOp    (ExtOp),
        .MemtoReg (MemtoReg),
        .RegWr    (RegWr),
        .MemWr    (MemWr),
        .retire   (retire),
        .mem_err  (mem_err)
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        .illegal  (illegal)
`endif
    );

    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic       branch;
        logic       jump;
        logic       regdst;
        logic       alusrc;
        logic [2:0] aluctr;
        logic       extop;
        logic       memtoreg;
        logic       regwr;
        logic       memwr;
        logic       retire;
    } outs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fuc;
        int         cyc;
        outs_t      exp;
    } vec_t;

    vec_t  vecs[$];
    outs_t sb_out[$];
    int    sb_cyc[$];
    int    npass = 0;
    int    ntot  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic outs_t cur();
        outs_t o;
        o.pcwr     = PCWr;
        o.irwr     = IRWr;
        o.branch   = Branch;
        o.jump     = Jump;
        o.regdst   = RegDst;
        o.alusrc   = ALUsrc;
        o.aluctr   = ALUctr;
        o.extop    = ExtOp;
        o.memtoreg = MemtoReg;
        o.regwr    = RegWr;
        o.memwr    = MemWr;
        o.retire   = retire;
        return o;
    endfunction

    // expected outputs of a normally completing final cycle
    function automatic outs_t mko(
        logic br, logic jp, logic rd, logic as,
        logic [2:0] alu, logic ex, logic mt, logic rw);
        outs_t o;
        o          = '0;
        o.pcwr     = 1'b1;
        o.retire   = 1'b1;
        o.branch   = br;
        o.jump     = jp;
        o.regdst   = rd;
        o.alusrc   = as;
        o.aluctr   = alu;
        o.extop    = ex;
        o.memtoreg = mt;
        o.regwr    = rw;
        return o;
    endfunction

    function automatic void addv(
        string nm, logic [5:0] op, logic [5:0] fn,
        int cyc, outs_t e);
        vec_t v;
        v.name = nm;
        v.op   = op;
        v.fuc  = fn;
        v.cyc  = cyc;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Runs one instruction from IF until PCWr; mem_rdy high from
    // cycle rdy_cyc on. Op/Fuc are scrambled after IF.
    task automatic run(
        input  logic [5:0] op, input logic [5:0] fn,
        input  int rdy_cyc,
        output int endc, output outs_t s,
        output int nmw, output int stray, output int irw1);
        Op    = op;
        Fuc   = fn;
        endc  = -1;
        nmw   = 0;
        stray = 0;
        irw1  = 0;
        s     = '0;
        for (int c = 1; c <= 64; c++) begin
            mem_rdy = (c >= rdy_cyc);
            if (c == 2) begin
                Op  = 6'b111111;
                Fuc = 6'b111111;
            end
            #1;
            s = cur();
            if (c == 1) irw1 = int'(IRWr);
            nmw += int'(MemWr);
            if (PCWr) begin
                endc = c;
                @(posedge clk);
                #1;
                break;
            end
            stray += int'(RegWr);
            @(posedge clk);
            #1;
        end
        mem_rdy = 1'b0;
        if (endc < 0) pulse_rst();
    endtask

    initial begin
        int    endc, nmw, stray, irw1;
        outs_t s, e;

        rst     = 1'b1;
        Op      = 6'd0;
        Fuc     = 6'd0;
        mem_rdy = 1'b0;

        addv("addu",  6'b000000, 6'b100001, 4,
             mko(0, 0, 1, 0, 3'b000, 0, 0, 1));
        addv("subu",  6'b000000, 6'b100011, 4,
             mko(0, 0, 1, 0, 3'b001, 0, 0, 1));
        addv("and",   6'b000000, 6'b100100, 4,
             mko(0, 0, 1, 0, 3'b010, 0, 0, 1));
        addv("or",    6'b000000, 6'b100101, 4,
             mko(0, 0, 1, 0, 3'b011, 0, 0, 1));
        addv("slt",   6'b000000, 6'b101010, 4,
             mko(0, 0, 1, 0, 3'b100, 0, 0, 1));
        addv("ori",   6'b001101, 6'b000000, 4,
             mko(0, 0, 0, 1, 3'b011, 0, 0, 1));
        addv("addiu", 6'b001001, 6'b000000, 4,
             mko(0, 0, 0, 1, 3'b000, 1, 0, 1));
        addv("beq",   6'b000100, 6'b000000, 3,
             mko(1, 0, 0, 0, 3'b001, 0, 0, 0));
        addv("j",     6'b000010, 6'b000000, 2,
             mko(0, 1, 0, 0, 3'b000, 0, 0, 0));
        addv("lw",    6'b100011, 6'b000000, 5,
             mko(0, 0, 0, 0, 3'b000, 0, 1, 1));
`ifndef MC_ILLEGAL_TRAP_EN
        addv("nop_op", 6'b111111, 6'b000000, 4,
             mko(0, 0, 0, 0, 3'b000, 0, 0, 0));
        addv("nop_fn", 6'b000000, 6'b000000, 4,
             mko(0, 0, 0, 0, 3'b000, 0, 0, 0));
`endif

        // reset held for three clock edges
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_outs", int'(cur()), 0);
            if (i > 0) chk("rst_mem_err", int'(mem_err), 0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            sb_out.push_back(vecs[i].exp);
            sb_cyc.push_back(vecs[i].cyc);
            run(vecs[i].op, vecs[i].fuc, 0,
                endc, s, nmw, stray, irw1);
            e = sb_out.pop_front();
            chk({vecs[i].name, "_cyc"}, endc, sb_cyc.pop_front());
            chk({vecs[i].name, "_outs"}, int'(s), int'(e));
            chk({vecs[i].name, "_irwr1"}, irw1, 1);
            chk({vecs[i].name, "_stray_regwr"}, stray, 0);
        end

        // lw with two wait cycles: MEM in cycles 4..6, WB in 7
        run(6'b100011, 6'b000000, 6, endc, s, nmw, stray, irw1);
        chk("lw_wait_cyc", endc, 7);
        chk("lw_wait_outs", int'(s),
            int'(mko(0, 0, 0, 0, 3'b000, 0, 1, 1)));
        chk("lw_wait_memwr", nmw, 0);

        // sw ready on first MEM cycle
        run(6'b101011, 6'b000000, 0, endc, s, nmw, stray, irw1);
        chk("sw_cyc", endc, 4);
        chk("sw_retire", int'(s.retire), 1);
        chk("sw_memwr_seen", int'(nmw > 0), 1);
        chk("sw_stray_regwr", stray, 0);

        // mem_rdy arrives in the would-be timeout cycle
        run(6'b101011, 6'b000000, 20, endc, s, nmw, stray, irw1);
        chk("sw_late_cyc", endc, 20);
        chk("sw_late_retire", int'(s.retire), 1);
        chk("sw_late_mem_err", int'(mem_err), 0);

        // mem_rdy never comes: 16 MemWr cycles then abort
        run(6'b101011, 6'b000000, 1000, endc, s, nmw, stray, irw1);
        chk("sw_to_cyc", endc, 20);
        chk("sw_to_memwr_cnt", nmw, 16);
        chk("sw_to_retire", int'(s.retire), 0);
        chk("sw_to_memwr_end", int'(s.memwr), 0);
        chk("sw_to_regwr", stray + int'(s.regwr), 0);
        chk("sw_to_mem_err", int'(mem_err), 1);
        chk("sw_to_next_if", int'(IRWr), 1);

        // mem_err is sticky across later instructions
        run(6'b000000, 6'b100001, 0, endc, s, nmw, stray, irw1);
        chk("sticky_cyc", endc, 4);
        chk("sticky_mem_err", int'(mem_err), 1);

`ifdef MC_ILLEGAL_TRAP_EN
        Op  = 6'b111111;
        Fuc = 6'b000000;
        for (int c = 1; c <= 6; c++) begin
            #1;
            if (c >= 3) begin
                chk("trap_illegal", int'(illegal), 1);
                chk("trap_outs", int'(cur()), 0);
            end
            @(posedge clk);
            #1;
        end
        pulse_rst();
        #1;
        chk("trap_cleared", int'(illegal), 0);
        chk("trap_next_if", int'(IRWr), 1);
        @(posedge clk);
        #1;
        pulse_rst();
`endif

        // reset during MEM of a stalled sw
        Op      = 6'b101011;
        Fuc     = 6'b000000;
        mem_rdy = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
        end
        #1;
        chk("rstmem_memwr_before", int'(MemWr), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rstmem_outs", int'(cur()), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rstmem_next_if", int'(IRWr), 1);
        chk("rstmem_retire", int'(retire), 0);
        chk("rstmem_mem_err", int'(mem_err), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
